// File: rtl/re_map_out_buf_if.sv
`default_nettype none
// ============================================================================
// re_map_out_buf_if : sample-in / stream-out / frame-stats bundle of the
//                     remapper output buffer.
// Revision 1.0
// ============================================================================
interface re_map_out_buf_if #(
  parameter int M2_W = 15,
  parameter int AW   = 3
);
  logic [M2_W-1:0] m2;
  logic            m2_valid;
  logic            m2_last;
  logic [M2_W-1:0] out_data;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  logic [AW:0]     level;
  logic            overflow;
  logic            clr_ovf;
  logic [M2_W-1:0] frm_min;
  logic [M2_W-1:0] frm_max;
  logic            frm_done;

  // master: remap stage plus consumer side; slave: the buffer itself
  modport master (
    output m2, m2_valid, m2_last, out_ready, clr_ovf,
    input  out_data, out_last, out_valid, level, overflow,
           frm_min, frm_max, frm_done
  );

  modport slave (
    input  m2, m2_valid, m2_last, out_ready, clr_ovf,
    output out_data, out_last, out_valid, level, overflow,
           frm_min, frm_max, frm_done
  );
endinterface
`default_nettype wire

// File: rtl/re_map_out_buf.sv
`default_nettype none
// ============================================================================
// re_map_out_buf : FIFO buffer for remapped m2 samples with sticky overflow
//                  and per-frame unsigned min/max statistics.
// Revision 1.0
// ============================================================================
module re_map_out_buf #(
  parameter int M2_W  = 15,
  parameter int DEPTH = 8,
  parameter int AW    = 3   // log2(DEPTH); pointers wrap naturally at DEPTH
) (
  input  wire logic        clk,
  input  wire logic        rst,
  re_map_out_buf_if.slave  bus
);

  localparam logic [AW:0]     LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [M2_W-1:0] ALL_ONES = '1;

  // Storage carries {last, sample}; contents are intentionally not reset.
  logic [M2_W:0]   mem_q [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            overflow_q, overflow_d;
  logic            frm_done_q, frm_done_d;
  logic [M2_W-1:0] frm_min_q, frm_min_d;
  logic [M2_W-1:0] frm_max_q, frm_max_d;
  logic [M2_W-1:0] run_min_q, run_min_d;
  logic [M2_W-1:0] run_max_q, run_max_d;

  logic            full;
  logic            wr;
  logic            rd;
  logic            close;
  logic [M2_W-1:0] acc_min;
  logic [M2_W-1:0] acc_max;
  logic [M2_W:0]   head;

  always_comb begin
    // Fullness comes from the registered level only, so a same-cycle read
    // never makes room for a write.
    full  = (level_q == LVL_FULL);
    wr    = bus.m2_valid & ~full;
    rd    = (level_q != '0) & bus.out_ready;
    close = bus.m2_valid & bus.m2_last;

    wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    case ({wr, rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    overflow_d = (bus.m2_valid & full) | (overflow_q & ~bus.clr_ovf);

    // Only accepted samples contribute, including the one closing a frame.
    acc_min = (wr && (bus.m2 < run_min_q)) ? bus.m2 : run_min_q;
    acc_max = (wr && (bus.m2 > run_max_q)) ? bus.m2 : run_max_q;

    frm_done_d = 1'b0;
    frm_min_d  = frm_min_q;
    frm_max_d  = frm_max_q;
    run_min_d  = acc_min;
    run_max_d  = acc_max;
    if (close) begin
      frm_done_d = 1'b1;
      frm_min_d  = acc_min;
      frm_max_d  = acc_max;
      run_min_d  = ALL_ONES;
      run_max_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      frm_done_q <= 1'b0;
      frm_min_q  <= '0;
      frm_max_q  <= '0;
      run_min_q  <= ALL_ONES;
      run_max_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      frm_done_q <= frm_done_d;
      frm_min_q  <= frm_min_d;
      frm_max_q  <= frm_max_d;
      run_min_q  <= run_min_d;
      run_max_q  <= run_max_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= {bus.m2_last, bus.m2};
    end
  end

  // Head is masked while empty so stale storage never leaks out.
  assign head          = mem_q[rd_ptr_q];
  assign bus.out_valid = (level_q != '0);
  assign bus.out_data  = bus.out_valid ? head[M2_W-1:0] : '0;
  assign bus.out_last  = bus.out_valid ? head[M2_W]     : 1'b0;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.frm_done  = frm_done_q;
  assign bus.frm_min   = frm_min_q;
  assign bus.frm_max   = frm_max_q;

endmodule
`default_nettype wire

// File: tb/tb_re_map_out_buf.sv
`default_nettype none
// ============================================================================
// tb_re_map_out_buf : directed self-checking bench for re_map_out_buf.
// Revision 1.0
// ============================================================================
module tb_re_map_out_buf;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  re_map_out_buf_if #(.M2_W(15), .AW(3)) bus ();

  re_map_out_buf #(.M2_W(15), .DEPTH(8), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [14:0] d, input logic l);
    bus.m2       = d;
    bus.m2_valid = 1'b1;
    bus.m2_last  = l;
    tick();
    bus.m2_valid = 1'b0;
    bus.m2_last  = 1'b0;
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.m2        = '0;
    bus.m2_valid  = 1'b0;
    bus.m2_last   = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    chk("rst_level",    32'(bus.level),     32'h0);
    chk("rst_valid",    32'(bus.out_valid), 32'h0);
    chk("rst_data",     32'(bus.out_data),  32'h0);
    chk("rst_last",     32'(bus.out_last),  32'h0);
    chk("rst_ovf",      32'(bus.overflow),  32'h0);
    chk("rst_done",     32'(bus.frm_done),  32'h0);
    chk("rst_min",      32'(bus.frm_min),   32'h0);
    chk("rst_max",      32'(bus.frm_max),   32'h0);
    rst = 1'b0;

    // single write, one-cycle latency
    put(15'h0010, 1'b0);
    chk("t1_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_data",  32'(bus.out_data),  32'h10);
    chk("t1_level", 32'(bus.level),     32'h1);
    chk("t1_last",  32'(bus.out_last),  32'h0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t1_empty_valid", 32'(bus.out_valid), 32'h0);
    chk("t1_empty_data",  32'(bus.out_data),  32'h0);
    chk("t1_empty_level", 32'(bus.level),     32'h0);

    // fill past full: sample 9 dropped
    for (int i = 1; i <= 9; i++) put(15'(i), 1'b0);
    chk("t2_level", 32'(bus.level),    32'h8);
    chk("t2_ovf",   32'(bus.overflow), 32'h1);
    chk("t2_head",  32'(bus.out_data), 32'h1);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain", 32'(bus.out_data), 32'(i));
      tick();
    end
    bus.out_ready = 1'b0;
    chk("t2_empty", 32'(bus.out_valid), 32'h0);
    chk("t2_level0", 32'(bus.level),    32'h0);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    chk("t2_clr", 32'(bus.overflow), 32'h0);

    // frame of accepted samples 0x10,1..8,0x20..0x27 closes at 0x27
    for (int i = 0; i < 8; i++) put(15'(32'h20 + i), (i == 7));
    chk("t3_level",  32'(bus.level),    32'h8);
    chk("t3_done_a", 32'(bus.frm_done), 32'h1);
    chk("t3_min_a",  32'(bus.frm_min),  32'h1);
    chk("t3_max_a",  32'(bus.frm_max),  32'h27);
    // full with read: drop, set wins over clear, empty frame closes
    bus.m2        = 15'h0055;
    bus.m2_valid  = 1'b1;
    bus.m2_last   = 1'b1;
    bus.out_ready = 1'b1;
    bus.clr_ovf   = 1'b1;
    tick();
    bus.m2_valid  = 1'b0;
    bus.m2_last   = 1'b0;
    bus.clr_ovf   = 1'b0;
    chk("t3_level7", 32'(bus.level),    32'h7);
    chk("t3_ovf",    32'(bus.overflow), 32'h1);
    chk("t3_done_b", 32'(bus.frm_done), 32'h1);
    chk("t3_min_b",  32'(bus.frm_min),  32'h7fff);
    chk("t3_max_b",  32'(bus.frm_max),  32'h0);
    for (int i = 1; i <= 7; i++) begin
      chk("t3_drain", 32'(bus.out_data), 32'h20 + 32'(i));
      chk("t3_last",  32'(bus.out_last), (i == 7) ? 32'h1 : 32'h0);
      tick();
    end
    bus.out_ready = 1'b0;
    chk("t3_done_off", 32'(bus.frm_done), 32'h0);
    chk("t3_min_hold", 32'(bus.frm_min),  32'h7fff);
    chk("t3_level0",   32'(bus.level),    32'h0);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    chk("t3_clr", 32'(bus.overflow), 32'h0);

    // frame 0x300, 0x5, 0x7fff(last) streaming through
    bus.out_ready = 1'b1;
    put(15'h0300, 1'b0);
    chk("t4_d0",    32'(bus.out_data), 32'h300);
    chk("t4_lvl0",  32'(bus.level),    32'h1);
    chk("t4_last0", 32'(bus.out_last), 32'h0);
    put(15'h0005, 1'b0);
    chk("t4_d1",    32'(bus.out_data), 32'h5);
    chk("t4_last1", 32'(bus.out_last), 32'h0);
    put(15'h7fff, 1'b1);
    chk("t4_d2",    32'(bus.out_data), 32'h7fff);
    chk("t4_last2", 32'(bus.out_last), 32'h1);
    chk("t4_done",  32'(bus.frm_done), 32'h1);
    chk("t4_min",   32'(bus.frm_min),  32'h5);
    chk("t4_max",   32'(bus.frm_max),  32'h7fff);
    tick();
    chk("t4_pulse", 32'(bus.frm_done), 32'h0);
    chk("t4_lvl",   32'(bus.level),    32'h0);
    chk("t4_hold",  32'(bus.frm_max),  32'h7fff);

    // continuous write+read across pointer wrap
    for (int i = 0; i < 20; i++) begin
      put(15'(32'h100 + i), 1'b0);
      chk("t5_level", 32'(bus.level),    32'h1);
      chk("t5_data",  32'(bus.out_data), 32'h100 + 32'(i));
    end
    tick();
    chk("t5_level0", 32'(bus.level), 32'h0);
    bus.out_ready = 1'b0;

    // reset mid-frame with five entries held
    for (int i = 0; i < 5; i++) put(15'(32'h40 + i), 1'b0);
    chk("t6_level5", 32'(bus.level), 32'h5);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_level", 32'(bus.level),     32'h0);
    chk("t6_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("t6_rst_data",  32'(bus.out_data),  32'h0);
    chk("t6_rst_min",   32'(bus.frm_min),   32'h0);
    chk("t6_rst_max",   32'(bus.frm_max),   32'h0);
    tick();
    rst = 1'b0;
    chk("t6_rst_done", 32'(bus.frm_done), 32'h0);
    bus.out_ready = 1'b1;
    put(15'h0700, 1'b0);
    put(15'h0600, 1'b1);
    chk("t6_done", 32'(bus.frm_done), 32'h1);
    chk("t6_min",  32'(bus.frm_min),  32'h600);
    chk("t6_max",  32'(bus.frm_max),  32'h700);
    bus.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
